// File: rtl/coa_pkg.sv
// Shared definitions for the bit-serial adder controller.
package coa_pkg;

  // Controller states; the encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width used by integrators that do not override WIDTH.
  localparam int ADD_W = 8;

endpackage

// File: rtl/FA.sv
// One-bit full-adder cell, shared combinational bit slice.
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks a single full-adder cell across the
// operands LSB-first, one bit per clock, holding the carry in a flip-flop.
// Result and carry-out are registered and updated only on completion.
module serial_add_ctrl
  import coa_pkg::*;
#(
  parameter int WIDTH = ADD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  // Only the upper WIDTH-1 bits of the partial-sum accumulator are ever
  // read back: bit 0 is shifted out on the very next step, so it is not kept.
  logic [WIDTH-2:0]   acc_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   next_acc_s;
  logic               last_bit_s;

  FA u_fa (
    .A    (a_sh_r[0]),
    .B    (b_sh_r[0]),
    .Cin  (carry_r),
    .Sum  (fa_sum_s),
    .Cout (fa_cout_s)
  );

  // New sum bit enters at the MSB so that after WIDTH steps the first bit
  // computed has arrived at bit 0.
  assign next_acc_s = {fa_sum_s, acc_r};
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign cout  = cout_r;

  // Controller FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        // DONE accepts a new request exactly like IDLE, giving back-to-back
        // operation without a bubble; the only difference is the done pulse.
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
            acc_r   <= '0;
            state_r <= RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        // One bit per cycle; start is ignored while running.
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          acc_r   <= next_acc_s[WIDTH-1:1];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_r   <= next_acc_s;
            cout_r  <= fa_cout_s;
            state_r <= DONE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= RUN;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 4-bit instance share clock and
// reset. A transaction-level model predicts every output on every cycle;
// directed tests add literal expectations for results and latency.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_v [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        cin_v   [2];
  logic        ready_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];
  logic        cout_v  [2];
  logic [31:0] sum_v   [2];
  logic [7:0]  sum8;
  logic [3:0]  sum4;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  assign sum_v[0] = {24'd0, sum8};
  assign sum_v[1] = {28'd0, sum4};

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum8), .cout(cout_v[0])
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum4), .cout(cout_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  // Transaction model: an accepted request occupies the unit for W edges,
  // then the true sum of the captured operands appears with a done pulse.
  logic        m_inf  [2];
  logic        m_done [2];
  logic [31:0] m_sum  [2];
  logic        m_cout [2];
  logic [32:0] m_res  [2];
  int          m_fin  [2];
  int          m_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge <= 0;
      for (int i = 0; i < 2; i++) begin
        m_inf[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_sum[i]  <= 32'd0;
        m_cout[i] <= 1'b0;
        m_res[i]  <= 33'd0;
        m_fin[i]  <= 0;
      end
    end else begin
      m_edge <= m_edge + 1;
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_inf[i]) begin
          if (start_v[i]) begin
            m_inf[i] <= 1'b1;
            m_fin[i] <= m_edge + w_of(i);
            m_res[i] <= {1'b0, a_v[i] & ((32'd1 << w_of(i)) - 32'd1)}
                      + {1'b0, b_v[i] & ((32'd1 << w_of(i)) - 32'd1)}
                      + {32'd0, cin_v[i]};
          end
        end else if (m_edge == m_fin[i]) begin
          m_inf[i]  <= 1'b0;
          m_done[i] <= 1'b1;
          m_sum[i]  <= m_res[i][31:0] & ((32'd1 << w_of(i)) - 32'd1);
          m_cout[i] <= m_res[i][w_of(i)];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if ({ready_v[i], busy_v[i], done_v[i], cout_v[i], sum_v[i]} !==
            {!m_inf[i], m_inf[i], m_done[i], m_cout[i], m_sum[i]}) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d t=%0t: rdy/bsy/dn/co/sum got %b%b%b%b/%0h expected %b%b%b%b/%0h",
                   i, $time, ready_v[i], busy_v[i], done_v[i], cout_v[i], sum_v[i],
                   !m_inf[i], m_inf[i], m_done[i], m_cout[i], m_sum[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic wait_ready(input int i);
    int k = 0;
    while (!ready_v[i] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_ready", {63'd0, ready_v[i]}, 64'd1);
  endtask

  // One addition; done must rise W edges after the accepting edge
  // (W+1 cycles counting the cycle in which start is presented).
  task automatic run_add(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [31:0] esum, input logic ecout,
                         input string nm);
    int lat;
    int bcnt;
    wait_ready(i);
    start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; cin_v[i] = c;
    @(posedge clk); #1;
    start_v[i] = 1'b0; a_v[i] = $urandom; b_v[i] = $urandom; cin_v[i] = 1'b1;
    lat  = 0;
    bcnt = busy_v[i] ? 1 : 0;
    while (!done_v[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[i]) bcnt++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(w_of(i)));
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(w_of(i)));
    chk({nm, "_sum"}, {32'd0, sum_v[i]}, {32'd0, esum});
    chk({nm, "_cout"}, {63'd0, cout_v[i]}, {63'd0, ecout});
  endtask

  initial begin
    int ndone;
    int d1, d2;
    logic [31:0] s1, s2, s3;
    logic c1, c2, c3;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; a_v[i] = 32'd0; b_v[i] = 32'd0; cin_v[i] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", {63'd0, ready_v[i]}, 64'd1);
      chk("reset_busy",  {63'd0, busy_v[i]},  64'd0);
      chk("reset_done",  {63'd0, done_v[i]},  64'd0);
      chk("reset_sum",   {32'd0, sum_v[i]},   64'd0);
      chk("reset_cout",  {63'd0, cout_v[i]},  64'd0);
    end

    // Basic addition and carry-out/wrap cases.
    run_add(0, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0, "t1");
    run_add(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, "t2a");
    run_add(0, 32'hFF, 32'h00, 1'b1, 32'h00, 1'b1, "t2b");

    // start pulsed mid-run with different operands is ignored.
    wait_ready(0);
    start_v[0] = 1'b1; a_v[0] = 32'h10; b_v[0] = 32'h20; cin_v[0] = 1'b0;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_v[0] = 1'b1; a_v[0] = 32'hFF;
    @(posedge clk); #1 start_v[0] = 1'b0;
    ndone = 0; s3 = 32'd0; c3 = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin ndone++; s3 = sum_v[0]; c3 = cout_v[0]; end
    end
    chk("t3_done_count", 64'(ndone), 64'd1);
    chk("t3_sum", {32'd0, s3}, 64'h30);
    chk("t3_cout", {63'd0, c3}, 64'd0);

    // start held high: second request accepted in the DONE cycle.
    wait_ready(0);
    start_v[0] = 1'b1; a_v[0] = 32'h01; b_v[0] = 32'h01; cin_v[0] = 1'b0;
    @(posedge clk); #1;
    a_v[0] = 32'h80; b_v[0] = 32'h80; cin_v[0] = 1'b1;
    d1 = -1; d2 = -1; s1 = 32'd0; s2 = 32'd0; c1 = 1'b0; c2 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 9) start_v[0] = 1'b0;
      if (done_v[0]) begin
        if (d1 < 0) begin d1 = k; s1 = sum_v[0]; c1 = cout_v[0]; end
        else if (d2 < 0) begin d2 = k; s2 = sum_v[0]; c2 = cout_v[0]; end
        else d2 = 1000;
      end
    end
    chk("t4_first_done", 64'(d1), 64'd8);
    chk("t4_second_done", 64'(d2), 64'd17);
    chk("t4_sum1", {32'd0, s1}, 64'h02);
    chk("t4_cout1", {63'd0, c1}, 64'd0);
    chk("t4_sum2", {32'd0, s2}, 64'h01);
    chk("t4_cout2", {63'd0, c2}, 64'd1);

    // Asynchronous reset in the middle of a run.
    wait_ready(0);
    start_v[0] = 1'b1; a_v[0] = 32'h77; b_v[0] = 32'h11; cin_v[0] = 1'b0;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", {63'd0, ready_v[0]}, 64'd1);
    chk("t5_busy",  {63'd0, busy_v[0]},  64'd0);
    chk("t5_done",  {63'd0, done_v[0]},  64'd0);
    chk("t5_sum",   {32'd0, sum_v[0]},   64'd0);
    chk("t5_cout",  {63'd0, cout_v[0]},  64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    run_add(0, 32'h33, 32'h44, 1'b1, 32'h78, 1'b0, "t5_after");

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          run_add(1, 32'(x), 32'(y), c[0], 32'((x + y + c) % 16), ((x + y + c) >= 16),
                  $sformatf("t6 a=%0h b=%0h c=%0d", x, y, c));
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences a single 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Operands are captured on a start handshake and shifted LSB-first through the cell.
- Carry is held in a flip-flop between bits.
- Result is presented with a one-cycle done pulse.
- Sits between a simple datapath/ALU sequencer and the shared full-adder cell, trading area for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready is high
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- ready  output  1  high in IDLE and DONE (start will be accepted)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held until next completion

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ready=1, busy=0, done=0.
  - sum=0, cout=0.
  - Shift registers, carry FF and counter are 0.
  - Any in-flight addition is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and moves to RUN.
  - start=0 holds IDLE.
- RUN (busy=1, ready=0), every cycle:
  - The FA cell is fed a_sh[0], b_sh[0], carry.
  - acc <= {fa_sum, acc[WIDTH-1:1]} (fills MSB-first so LSB lands at bit 0).
  - carry <= fa_cout.
  - a_sh, b_sh shift right by 1 (zero fill).
  - cnt <= cnt+1.
  - When cnt==WIDTH-1: sum <= {fa_sum, acc[WIDTH-1:1]}, cout <= fa_cout, go to DONE.
  - start is ignored throughout RUN; no queueing and no error flag.
- DONE:
  - done=1 and ready=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE and goes directly to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: start accepted at edge N → done high in the cycle following edge N+WIDTH. Throughput is one addition per WIDTH+1 cycles back-to-back.
- sum/cout change only at the RUN→DONE edge; intermediate partial sums are never visible on the outputs.
- Operand inputs a, b, cin may change freely after the accepting edge.
- Overflow: cout is the true carry out of bit WIDTH-1; sum wraps modulo 2^WIDTH.
- done and busy are never high simultaneously; ready == !busy.
- Illegal state encodings recover to IDLE on the next clock.

Decomposition:
- Shared package coa_pkg:
  - state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - localparam default width constant ADD_W=8.
- One sub-module: the team's existing 1-bit full-adder cell FA (ports A, B, Cin, Sum, Cout), instantiated once as the combinational bit slice.
- Everything else (FSM, counter, shift registers, carry FF, result registers) lives in serial_add_ctrl.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start one cycle → busy for 8 cycles, done pulse 9 cycles after accept, sum=8'h96, cout=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; then a=8'hFF, b=8'h00, cin=1 → sum=8'h00, cout=1.
3. Start accepted with a=8'h10, b=8'h20; pulse start again with a=8'hFF at RUN cycle 3 → ignored, result is still sum=8'h30, cout=0, exactly one done pulse.
4. Hold start=1 continuously with operands (8'h01, 8'h01, 0) then (8'h80, 8'h80, 1) → second accepted in the DONE cycle; done pulses 9 cycles apart; results 8'h02/0 then 8'h01/1.
5. rst_n low during RUN cycle 4 → outputs immediately ready=1, busy=0, done=0, sum=0, cout=0; no done pulse after release; the next start completes normally.
6. WIDTH=4 build, exhaustive sweep of all 512 {a, b, cin} combinations → every {cout, sum} equals a+b+cin, and done latency is always 5 cycles.
